psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; clk and rst SHALL be the first ports.
REQ-002 Parameter IN_W, default 20, SHALL set the input partial-sum width, matching the adder tree output.
REQ-003 Parameter ACC_W, default 32, SHALL set the internal accumulator width.
REQ-004 Parameter OUT_W, default 16, SHALL set the output activation width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cfg_len  input  8  beats per output; sampled on the first beat of a group; 0 means 1.
REQ-008 cfg_shift  input  4  arithmetic right-shift amount; sampled on the first beat of a group.
REQ-009 i_valid  input  1  i_psum is valid.
REQ-010 i_ready  output  1  block accepts a beat; a beat transfers when i_valid and i_ready are both high.
REQ-011 i_psum  input  IN_W  signed partial sum from the adder tree.
REQ-012 o_valid  output  1  o_data is valid.
REQ-013 o_ready  input  1  downstream accepts o_data.
REQ-014 o_data  output  OUT_W  signed rounded and saturated result.
REQ-015 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states, with these transitions:
- IDLE: no beats held.
- ACC: at least 1 beat held, group incomplete.
- OUT: result held.
REQ-017 IDLE, beat accepted, effective len = 1 -> OUT.
REQ-018 IDLE, beat accepted, effective len > 1 -> ACC, with cnt = 1.
REQ-019 ACC, beat accepted, cnt+1 = len -> OUT; otherwise cnt increments.
REQ-020 OUT, o_valid and o_ready -> IDLE.
REQ-021 i_ready SHALL be 1 in IDLE and ACC and 0 in OUT; no input beat SHALL be accepted in the cycle a result drains.
REQ-022 On the first beat, acc SHALL load sign-extended i_psum; on each later beat, acc SHALL become acc + sign-extended i_psum.
REQ-023 ACC_W SHALL cover 256 × 2^(IN_W-1) with no wrap; no overflow detection is required.
REQ-024 Cycles with i_valid low SHALL leave acc and cnt unchanged, including in ACC.
REQ-025 The result SHALL be computed as follows:
- s = latched shift.
- r = (acc + (s>0 ? 2^(s-1) : 0)) >>> s, i.e. round half up.
- r SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 The result SHALL be registered into o_data on the same edge that accepts the last beat, so o_valid rises exactly 1 cycle after the last-beat handshake.
REQ-027 o_data SHALL hold stable while o_valid is high and o_ready is low.
REQ-028 o_valid SHALL be high only in OUT.
REQ-029 Changes on cfg_len or cfg_shift during ACC or OUT SHALL have no effect on the current group.

Reset
REQ-030 Reset SHALL clear all state at any time, including mid-group and in OUT, and the held partial group SHALL be discarded.
REQ-031 Reset values SHALL be:
- state = IDLE, acc = 0, cnt = 0.
- Latched len and shift = 0.
- o_data = 0, o_valid = 0, o_busy = 0.
- i_ready = 1 once rst deasserts.

Structure
REQ-032 The FSM state enum and the width constants IN_W, ACC_W and OUT_W SHALL live in shared package sparse_cnn_pkg.
REQ-033 Rounding, shifting and saturation SHALL be one combinational sub-module, round_sat (ACC_W in, OUT_W out, shift input), reusable by other requantization stages.
REQ-034 The remaining RTL SHALL be a single FSM plus counter plus accumulator and output register.

Verification
REQ-035 The bench SHALL drive len=4, shift=0 with beats 100, 200, -50, 25 back-to-back and o_ready=1, and SHALL check o_data=275 with o_valid high exactly 1 cycle after the 4th beat.
REQ-036 The bench SHALL drive len=2, shift=4 with beats 24, 0 and check o_data=2, then beats -24, 0 and check o_data=-1.
REQ-037 The bench SHALL drive len=3, shift=0 with 524287 ×3 and check o_data=32767, then len=2 with -524288 ×2 and check o_data=-32768.
REQ-038 The bench SHALL drive len=2 with gaps in i_valid, hold o_ready=0 for 5 cycles and change cfg mid-group, and SHALL check:
- o_data stable and i_ready=0 throughout the stall.
- Sum unaffected by the cfg change.
- Return to IDLE 1 cycle after o_ready=1.
REQ-039 The bench SHALL drive len=4 with beats 10, 20, assert rst, then send a new group of len=1 with beat -7, and SHALL check o_data=-7 with the old partial sum not included.
REQ-040 The bench SHALL drive len=0 with beat 5 and check o_data=5 after 1 beat.

Source files
------------

// File: rtl/sparse_cnn_pkg.sv
// Shared widths, FSM state encoding and small helpers for the sparse CNN datapath.
// Imported by the accumulator and requantization stages.
package sparse_cnn_pkg;

   localparam int IN_W    = 20;
   localparam int ACC_W   = 32;
   localparam int OUT_W   = 16;
   localparam int LEN_W   = 8;
   localparam int SHIFT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } acc_state_t;

   // A programmed length of zero is treated as a single-beat group.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/round_sat.sv
// Requantizer: round-half-up arithmetic right shift, then saturate to the signed output range.
// Purely combinational; no state and no flow control.
module round_sat #(
   parameter int ACC_W   = sparse_cnn_pkg::ACC_W,
   parameter int OUT_W   = sparse_cnn_pkg::OUT_W,
   parameter int SHIFT_W = sparse_cnn_pkg::SHIFT_W
) (
   input  logic [ACC_W-1:0]   i_acc,
   input  logic [SHIFT_W-1:0] i_shift,
   output logic [OUT_W-1:0]   o_data
);

   // One guard bit so adding the rounding bias can never wrap.
   logic signed [ACC_W:0]   w_ext;
   logic        [ACC_W:0]   w_bias;
   logic signed [ACC_W:0]   w_rnd;
   logic signed [ACC_W:0]   w_shr;
   logic [ACC_W-OUT_W+1:0]  w_hi;

   assign w_ext  = $signed({i_acc[ACC_W-1], i_acc});
   // (1 << s) >> 1 yields 2^(s-1) for s > 0 and 0 for s == 0.
   assign w_bias = ({{ACC_W{1'b0}}, 1'b1} << i_shift) >> 1;
   assign w_rnd  = w_ext + $signed(w_bias);
   assign w_shr  = w_rnd >>> i_shift;
   assign w_hi   = w_shr[ACC_W:OUT_W-1];

   always_comb begin
      o_data = w_shr[OUT_W-1:0];
      if (!((&w_hi) || !(|w_hi))) begin
         o_data = w_shr[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_len partial sums per group, then requantizes into a held output register.
// o_valid rises 1 cycle after the last-beat handshake; input is stalled (i_ready low) while a result is held.
module psum_accumulator
   import sparse_cnn_pkg::acc_state_t;
   import sparse_cnn_pkg::ST_IDLE;
   import sparse_cnn_pkg::ST_ACC;
   import sparse_cnn_pkg::ST_OUT;
   import sparse_cnn_pkg::eff_len;
#(
   parameter int IN_W  = sparse_cnn_pkg::IN_W,
   parameter int ACC_W = sparse_cnn_pkg::ACC_W,
   parameter int OUT_W = sparse_cnn_pkg::OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       cfg_len,
   input  logic [3:0]       cfg_shift,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [IN_W-1:0]  i_psum,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_busy
);

   acc_state_t       r_state;
   acc_state_t       w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [7:0]       r_cnt;
   logic [7:0]       r_len;
   logic [3:0]       r_shift;
   logic [OUT_W-1:0] r_data;

   logic             w_fire;
   logic             w_first;
   logic             w_last;
   logic [7:0]       w_len_eff;
   logic [7:0]       w_cnt_inc;
   logic [ACC_W-1:0] w_psum_sx;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [3:0]       w_shift;
   logic [OUT_W-1:0] w_rs_data;

   assign w_fire    = i_valid && i_ready;
   assign w_first   = (r_state == ST_IDLE);
   assign w_len_eff = eff_len(cfg_len);
   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_last    = w_first ? (w_len_eff == 8'd1) : (w_cnt_inc == r_len);
   assign w_psum_sx = {{(ACC_W-IN_W){i_psum[IN_W-1]}}, i_psum};
   assign w_acc_nxt = w_first ? w_psum_sx : (r_acc + w_psum_sx);
   // The first beat of a single-beat group must use the live shift, not the stale latch.
   assign w_shift   = w_first ? cfg_shift : r_shift;

   round_sat #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (4)
   ) u_round_sat (
      .i_acc   (w_acc_nxt),
      .i_shift (w_shift),
      .o_data  (w_rs_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      i_ready     = 1'b1;
      o_valid     = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (w_fire) w_state_nxt = w_last ? ST_OUT : ST_ACC;
         end
         ST_ACC: begin
            if (w_fire && w_last) w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            i_ready = 1'b0;
            o_valid = 1'b1;
            if (o_ready) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_shift <= '0;
         r_data  <= '0;
      end else if (w_fire) begin
         r_acc <= w_acc_nxt;
         r_cnt <= w_last ? 8'd0 : w_cnt_inc;
         if (w_first) begin
            r_len   <= w_len_eff;
            r_shift <= cfg_shift;
         end
         if (w_last) r_data <= w_rs_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expected results.
module tb_psum_accumulator;

   localparam int IN_W  = 20;
   localparam int OUT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       cfg_len;
   logic [3:0]       cfg_shift;
   logic             i_valid;
   logic             i_ready;
   logic [IN_W-1:0]  i_psum;
   logic             o_valid;
   logic             o_ready;
   logic [OUT_W-1:0] o_data;
   logic             o_busy;

   int checks   = 0;
   int failures = 0;

   psum_accumulator #(.IN_W(IN_W), .ACC_W(32), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_len   (cfg_len),
      .cfg_shift (cfg_shift),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_psum    (i_psum),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_busy    (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Presents one beat and advances past the accepting edge; valid stays high for back-to-back use.
   task automatic beat(input int v);
      i_valid = 1'b1;
      i_psum  = IN_W'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      i_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_result(input string tag, input int exp);
      i_valid = 1'b0;
      check_bit({tag, "_valid"}, o_valid, 1'b1);
      check_val({tag, "_data"}, $signed(o_data), exp);
      @(posedge clk);
      #1;
      check_bit({tag, "_drained"}, o_valid, 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      cfg_len   = 8'd0;
      cfg_shift = 4'd0;
      i_valid   = 1'b0;
      i_psum    = '0;
      o_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_bit("rst_valid", o_valid, 1'b0);
      check_bit("rst_busy", o_busy, 1'b0);
      check_val("rst_data", $signed(o_data), 0);
      rst = 1'b0;
      #1;
      check_bit("rst_ready", i_ready, 1'b1);

      // Four back-to-back beats, no shift.
      cfg_len = 8'd4; cfg_shift = 4'd0;
      beat(100); beat(200); beat(-50);
      check_bit("g1_valid_early", o_valid, 1'b0);
      check_bit("g1_busy", o_busy, 1'b1);
      beat(25);
      expect_result("g1", 275);
      check_bit("g1_idle", o_busy, 1'b0);

      // Round half up with shift 4: (24+8)>>4 = 2, (-24+8)>>>4 = -1.
      cfg_len = 8'd2; cfg_shift = 4'd4;
      beat(24); beat(0);
      expect_result("g2_pos", 2);
      beat(-24); beat(0);
      expect_result("g2_neg", -1);

      // Shift 1 on odd values: (3+1)>>1 = 2, (-3+1)>>>1 = -1.
      cfg_len = 8'd1; cfg_shift = 4'd1;
      beat(3);
      expect_result("g3_pos", 2);
      beat(-3);
      expect_result("g3_neg", -1);

      // Saturation at both rails.
      cfg_len = 8'd3; cfg_shift = 4'd0;
      beat(524287); beat(524287); beat(524287);
      expect_result("sat_hi", 32767);
      cfg_len = 8'd2;
      beat(-524288); beat(-524288);
      expect_result("sat_lo", -32768);

      // Valid gaps, cfg change mid-group, then a 5-cycle output stall.
      cfg_len = 8'd2; cfg_shift = 4'd0; o_ready = 1'b0;
      beat(30);
      idle_cycle();
      cfg_len = 8'd1; cfg_shift = 4'd3;
      idle_cycle();
      check_bit("gap_busy", o_busy, 1'b1);
      check_bit("gap_ready", i_ready, 1'b1);
      check_bit("gap_valid", o_valid, 1'b0);
      beat(12);
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1;
         i_psum  = IN_W'(999);
         check_bit("stall_valid", o_valid, 1'b1);
         check_bit("stall_ready", i_ready, 1'b0);
         check_val("stall_data", $signed(o_data), 42);
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      check_val("stall_data_end", $signed(o_data), 42);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      check_bit("stall_drain_valid", o_valid, 1'b0);
      check_bit("stall_drain_busy", o_busy, 1'b0);
      check_bit("stall_drain_ready", i_ready, 1'b1);

      // Reset mid-group discards the partial sum.
      cfg_len = 8'd4; cfg_shift = 4'd0;
      beat(10); beat(20);
      i_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_bit("midrst_busy", o_busy, 1'b0);
      check_bit("midrst_valid", o_valid, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      cfg_len = 8'd1;
      beat(-7);
      expect_result("post_rst", -7);

      // Length zero behaves as one beat.
      cfg_len = 8'd0; cfg_shift = 4'd0;
      beat(5);
      expect_result("len0", 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
